// File: rtl/mipi_csi_rx_lane_deskew.sv
// CSI-2 RX lane deskew: measures per-lane skew at packet start and delays each lane to align bytes.
// Optional status outputs (skew_o, err_count_o) are built when MIPI_LANE_DESKEW_STATUS_EN is defined.
module mipi_csi_rx_lane_deskew #(
  parameter int MIPI_GEAR   = 16,
  parameter int MIPI_LANES  = 4,
  parameter int ALIGN_DEPTH = 8,
  parameter int SKEW_W      = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [MIPI_LANES-1:0]           lane_mask_i,
  input  logic [MIPI_LANES-1:0]           bytes_valid_i,
  input  logic [MIPI_GEAR*MIPI_LANES-1:0] byte_i,
  output logic                            lane_valid_o,
  output logic [MIPI_GEAR*MIPI_LANES-1:0] lane_byte_o,
  output logic                            skew_err_o,
  output logic                            busy_o
`ifdef MIPI_LANE_DESKEW_STATUS_EN
  ,
  output logic [SKEW_W*MIPI_LANES-1:0]    skew_o,
  output logic [7:0]                      err_count_o
`endif
);
  // state     | meaning
  // IDLE      | latch lane mask, wait for the first active lane valid
  // CAPTURE   | count cycles, record the arrival offset of each active lane
  // ALIGNED   | emit delayed words while every active delayed valid is high
  // WAIT_IDLE | outputs invalid until all active input valids are low
  typedef enum logic [1:0] {IDLE, CAPTURE, ALIGNED, WAIT_IDLE} state_t;

  localparam int W = MIPI_GEAR * MIPI_LANES;
  localparam logic [SKEW_W-1:0] CNT_MAX = SKEW_W'(ALIGN_DEPTH - 1);

  state_t                state;
  logic [W-1:0]          byte_r;
  logic [MIPI_LANES-1:0] valid_r;
  logic [W-1:0]          hist_data [ALIGN_DEPTH];
  logic [MIPI_LANES-1:0] hist_vld  [ALIGN_DEPTH];
  logic [MIPI_LANES-1:0] mask_r;
  logic [MIPI_LANES-1:0] rec;
  logic [SKEW_W-1:0]     cnt;
  logic [SKEW_W-1:0]     skew     [MIPI_LANES];
  logic [SKEW_W-1:0]     dly      [MIPI_LANES];
  logic [SKEW_W-1:0]     skew_nxt [MIPI_LANES];
  logic [SKEW_W-1:0]     dly_new  [MIPI_LANES];
  logic [MIPI_LANES-1:0] hit_idle;
  logic [MIPI_LANES-1:0] hit_cap;
  logic [MIPI_LANES-1:0] rec_nxt;
  logic                  cap_done;
  logic                  dly_and;
  logic [W-1:0]          dly_data;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      byte_r  <= '0;
      valid_r <= '0;
      for (int k = 0; k < ALIGN_DEPTH; k++) begin
        hist_data[k] <= '0;
        hist_vld[k]  <= '0;
      end
    end else begin
      byte_r       <= byte_i;
      valid_r      <= bytes_valid_i;
      hist_data[0] <= byte_r;
      hist_vld[0]  <= valid_r;
      for (int k = 1; k < ALIGN_DEPTH; k++) begin
        hist_data[k] <= hist_data[k-1];
        hist_vld[k]  <= hist_vld[k-1];
      end
    end
  end

  always_comb begin
    hit_idle = valid_r & lane_mask_i;
    hit_cap  = valid_r & mask_r & ~rec;
    rec_nxt  = rec | hit_cap;
    cap_done = ((rec_nxt & mask_r) == mask_r);
    for (int i = 0; i < MIPI_LANES; i++) begin
      skew_nxt[i] = hit_cap[i] ? cnt : skew[i];
      // the last recorded lane defines max skew, so its delay is zero
      dly_new[i]  = mask_r[i] ? (cnt - skew_nxt[i]) : '0;
    end
  end

  always_comb begin
    dly_and  = 1'b1;
    dly_data = '0;
    for (int i = 0; i < MIPI_LANES; i++) begin
      if (mask_r[i]) begin
        for (int k = 0; k < ALIGN_DEPTH; k++) begin
          if (dly[i] == SKEW_W'(k)) begin
            dly_and = dly_and & hist_vld[k][i];
            dly_data[i*MIPI_GEAR +: MIPI_GEAR] = hist_data[k][i*MIPI_GEAR +: MIPI_GEAR];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      mask_r       <= '0;
      rec          <= '0;
      cnt          <= '0;
      lane_valid_o <= 1'b0;
      lane_byte_o  <= '0;
      skew_err_o   <= 1'b0;
      busy_o       <= 1'b0;
      for (int i = 0; i < MIPI_LANES; i++) begin
        skew[i] <= '0;
        dly[i]  <= '0;
      end
    end else begin
      skew_err_o   <= 1'b0;
      lane_valid_o <= 1'b0;
      lane_byte_o  <= '0;
      case (state)
        IDLE: begin
          mask_r <= lane_mask_i;
          cnt    <= '0;
          rec    <= '0;
          if (|hit_idle) begin
            rec    <= hit_idle;
            busy_o <= 1'b1;
            for (int i = 0; i < MIPI_LANES; i++) skew[i] <= '0;
            // all active lanes arrived together: skip CAPTURE entirely
            if (hit_idle == lane_mask_i) begin
              for (int i = 0; i < MIPI_LANES; i++) dly[i] <= '0;
              state <= ALIGNED;
            end else begin
              cnt   <= SKEW_W'(1);
              state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          rec <= rec_nxt;
          for (int i = 0; i < MIPI_LANES; i++) skew[i] <= skew_nxt[i];
          if (cnt != CNT_MAX) cnt <= cnt + SKEW_W'(1);
          if (cap_done) begin
            for (int i = 0; i < MIPI_LANES; i++) dly[i] <= dly_new[i];
            state <= ALIGNED;
          end else if (cnt == CNT_MAX) begin
            skew_err_o <= 1'b1;
            state      <= WAIT_IDLE;
          end
        end
        ALIGNED: begin
          lane_valid_o <= dly_and;
          if (dly_and) lane_byte_o <= dly_data;
          else         state       <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if ((valid_r & mask_r) == '0) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MIPI_LANE_DESKEW_STATUS_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      skew_o      <= '0;
      err_count_o <= '0;
    end else begin
      if (state == IDLE && (|hit_idle) && hit_idle == lane_mask_i) begin
        skew_o <= '0;
      end else if (state == CAPTURE && cap_done) begin
        for (int i = 0; i < MIPI_LANES; i++) skew_o[i*SKEW_W +: SKEW_W] <= dly_new[i];
      end
      if (state == CAPTURE && !cap_done && cnt == CNT_MAX && err_count_o != 8'hFF)
        err_count_o <= err_count_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mipi_csi_rx_lane_deskew.sv
// Directed and randomized bench for mipi_csi_rx_lane_deskew against a packet-level reference model.
module tb_mipi_csi_rx_lane_deskew;
  localparam int G  = 16;
  localparam int L  = 4;
  localparam int D  = 8;
  localparam int SW = 4;
  localparam int W  = G * L;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic [L-1:0]  lane_mask_i = '0;
  logic [L-1:0]  bytes_valid_i = '0;
  logic [W-1:0]  byte_i = '0;
  logic          lane_valid_o;
  logic [W-1:0]  lane_byte_o;
  logic          skew_err_o;
  logic          busy_o;
`ifdef MIPI_LANE_DESKEW_STATUS_EN
  logic [SW*L-1:0] skew_o;
  logic [7:0]      err_count_o;
  logic [SW*L-1:0] exp_skew = '0;
  int              exp_errs = 0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [G-1:0] wd [L][64];
  int st [L];
  int ln [L];

  always #5 clk_i = ~clk_i;

  mipi_csi_rx_lane_deskew #(
    .MIPI_GEAR(G), .MIPI_LANES(L), .ALIGN_DEPTH(D), .SKEW_W(SW)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .lane_mask_i(lane_mask_i),
    .bytes_valid_i(bytes_valid_i),
    .byte_i(byte_i),
    .lane_valid_o(lane_valid_o),
    .lane_byte_o(lane_byte_o),
    .skew_err_o(skew_err_o),
    .busy_o(busy_o)
`ifdef MIPI_LANE_DESKEW_STATUS_EN
    ,
    .skew_o(skew_o),
    .err_count_o(err_count_o)
`endif
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives one packet described by st[]/ln[] and checks every cycle against the packet model.
  task automatic run_packet(input logic [L-1:0] mask, input bit incr, input int abort_at);
    int first_s, last_s, minlen, maxend, horizon, k;
    bit err, aborted, act;
    logic          exp_vld;
    logic [W-1:0]  exp_byte;
    first_s = 1000; last_s = -1; minlen = 1000; maxend = 0; aborted = 1'b0;
    for (int i = 0; i < L; i++) begin
      for (int j = 0; j < 64; j++) wd[i][j] = incr ? G'(i * 4096 + j) : G'($urandom);
      if (mask[i]) begin
        if (st[i] < first_s) first_s = st[i];
        if (st[i] > last_s) last_s = st[i];
        if (ln[i] < minlen) minlen = ln[i];
        if (st[i] + ln[i] > maxend) maxend = st[i] + ln[i];
      end
    end
    err = (last_s - first_s) > D - 1;
    horizon = maxend + 6;
    lane_mask_i = mask;
    for (int c = 0; c <= horizon; c++) begin
      for (int i = 0; i < L; i++) begin
        act = mask[i] && c >= st[i] && c < st[i] + ln[i];
        bytes_valid_i[i] = act;
        byte_i[i*G +: G] = act ? wd[i][c - st[i]] : G'($urandom);
      end
      if (c == last_s + 3) lane_mask_i = L'($urandom);
      @(posedge clk_i); #1;
      k = c - last_s - 2;
      exp_vld = !err && k >= 0 && k < minlen;
      exp_byte = '0;
      if (exp_vld)
        for (int i = 0; i < L; i++) if (mask[i]) exp_byte[i*G +: G] = wd[i][k];
      chk("lane_valid", lane_valid_o, exp_vld);
      chk("lane_byte", lane_byte_o, exp_byte);
      chk("skew_err", skew_err_o, err && c == first_s + D);
      if (c <= first_s) chk("busy_pre", busy_o, 1'b0);
      else if (err ? (c <= first_s + D) : (c <= last_s + 2 + minlen)) chk("busy_pkt", busy_o, 1'b1);
      if (c == abort_at) begin
        reset_n_i = 1'b0;
        #1;
        chk("rst_valid", lane_valid_o, 1'b0);
        chk("rst_byte", lane_byte_o, '0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", skew_err_o, 1'b0);
        bytes_valid_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
`ifdef MIPI_LANE_DESKEW_STATUS_EN
        exp_skew = '0;
        exp_errs = 0;
`endif
        aborted = 1'b1;
        break;
      end
    end
    bytes_valid_i = '0;
    lane_mask_i = mask;
    if (!aborted) begin
      chk("busy_end", busy_o, 1'b0);
`ifdef MIPI_LANE_DESKEW_STATUS_EN
      if (err) begin
        if (exp_errs < 255) exp_errs++;
      end else begin
        exp_skew = '0;
        for (int i = 0; i < L; i++) if (mask[i]) exp_skew[i*SW +: SW] = SW'(last_s - st[i]);
      end
      chk("skew_o", skew_o, exp_skew);
      chk("err_count", err_count_o, exp_errs[7:0]);
`endif
    end
  endtask

  initial begin
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_valid", lane_valid_o, 1'b0);
    chk("reset_byte", lane_byte_o, '0);
    chk("reset_err", skew_err_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    reset_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    st = '{0, 0, 0, 0}; ln = '{32, 32, 32, 32}; run_packet(4'hF, 1'b1, -1);
    st = '{0, 2, 5, 1}; ln = '{40, 40, 40, 40}; run_packet(4'hF, 1'b1, -1);
    st = '{0, 0, 0, 7}; ln = '{20, 20, 20, 20}; run_packet(4'hF, 1'b0, -1);
    st = '{0, 0, 0, 8}; ln = '{20, 20, 20, 20}; run_packet(4'hF, 1'b0, -1);
    st = '{0, 1, 0, 0}; ln = '{30, 30, 0, 0};   run_packet(4'h3, 1'b0, -1);
    st = '{3, 0, 1, 2}; ln = '{40, 40, 40, 40}; run_packet(4'hF, 1'b0, 20);
    st = '{2, 0, 1, 3}; ln = '{25, 25, 25, 25}; run_packet(4'hF, 1'b0, -1);
    st = '{0, 0, 0, 0}; ln = '{40, 37, 40, 40}; run_packet(4'hF, 1'b1, -1);

    // an empty lane mask must never start a packet
    lane_mask_i = '0;
    bytes_valid_i = '1;
    for (int c = 0; c < 6; c++) begin
      byte_i = {$urandom, $urandom};
      @(posedge clk_i); #1;
      chk("mask0_busy", busy_o, 1'b0);
      chk("mask0_valid", lane_valid_o, 1'b0);
    end
    bytes_valid_i = '0;
    repeat (3) @(posedge clk_i);
    #1;

    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < L; i++) begin
        st[i] = $urandom_range(0, 9);
        ln[i] = $urandom_range(12, 30);
      end
      run_packet(L'($urandom_range(1, 15)), 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
